// File: rtl/carrier_phase_gen.sv
// Carrier NCO phase accumulator feeding the DDS streaming-phase port.
// The Doppler FCW is double-buffered: writes land in a pending register and are
// promoted to the active register only at start or on the last beat of an epoch,
// so carrier retunes stay aligned with code epochs.
//
// state | meaning
// IDLE  | no output, waiting for start
// PRIME | one cycle: load phase_init, clear sample count, promote pending FCW
// RUN   | streaming phase words, one per accepted beat
// STOP  | stop requested while a beat was stalled; hold it until accepted
module carrier_phase_gen #(
    parameter int ACC_W     = 32,
    parameter int PHASE_W   = 16,
    parameter int EPOCH_LEN = 4000,
    parameter int CNT_W     = 12
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               stop,
    input  logic [ACC_W-1:0]   cfg_fcw,
    input  logic               cfg_fcw_wr,
    input  logic [ACC_W-1:0]   cfg_phase_init,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic               epoch_tick,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCH_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   fcw_active_q, fcw_active_d;
    logic [ACC_W-1:0]   fcw_pending_q, fcw_pending_d;
    logic               pend_flag_q, pend_flag_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic               hs;
    logic               last_beat;

    // Output decode is purely from state/acc so a reset drops tvalid immediately.
    assign m_axis_phase_tvalid = (state_q == RUN) || (state_q == STOP);
    assign m_axis_phase_tdata  = acc_q[ACC_W-1 -: PHASE_W];
    assign busy                = (state_q != IDLE);
    assign hs                  = m_axis_phase_tvalid & m_axis_phase_tready;
    assign last_beat           = (sample_cnt_q == CNT_LAST);
    assign epoch_tick          = hs & last_beat;

    // Next-state, accumulator stepping, epoch counting and FCW promotion.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        fcw_active_d  = fcw_active_q;
        fcw_pending_d = fcw_pending_q;
        pend_flag_d   = pend_flag_q;
        sample_cnt_d  = sample_cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = PRIME;
            end
            PRIME: begin
                acc_d        = cfg_phase_init;
                sample_cnt_d = '0;
                if (pend_flag_q) fcw_active_d = fcw_pending_q;
                pend_flag_d  = 1'b0;
                state_d      = RUN;
            end
            RUN: begin
                if (stop) state_d = hs ? IDLE : STOP;
            end
            STOP: begin
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every accepted beat advances phase; the epoch's last beat promotes FCW
        // so the new step applies from the first beat of the next epoch.
        if (hs) begin
            acc_d = acc_q + fcw_active_q;
            if (last_beat) begin
                sample_cnt_d = '0;
                if (pend_flag_q) begin
                    fcw_active_d = fcw_pending_q;
                    pend_flag_d  = 1'b0;
                end
            end else begin
                sample_cnt_d = sample_cnt_q + CNT_ONE;
            end
        end

        // A write after any promotion above, so a same-cycle write stays pending.
        if (cfg_fcw_wr) begin
            fcw_pending_d = cfg_fcw;
            pend_flag_d   = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            fcw_active_q  <= '0;
            fcw_pending_q <= '0;
            pend_flag_q   <= 1'b0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            fcw_active_q  <= fcw_active_d;
            fcw_pending_q <= fcw_pending_d;
            pend_flag_q   <= pend_flag_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

endmodule

// File: tb/tb_carrier_phase_gen.sv
// Directed bench for carrier_phase_gen with an 8-beat epoch. Expected beats are
// queued when a run is set up and checked as the DDS side accepts them.
module tb_carrier_phase_gen;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [31:0] cfg_fcw;
    logic        cfg_fcw_wr;
    logic [31:0] cfg_phase_init;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        epoch_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // {tdata, epoch_tick} per accepted beat
    logic [16:0] sb[$];

    carrier_phase_gen #(
        .ACC_W(32), .PHASE_W(16), .EPOCH_LEN(8), .CNT_W(4)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .start               (start),
        .stop                (stop),
        .cfg_fcw             (cfg_fcw),
        .cfg_fcw_wr          (cfg_fcw_wr),
        .cfg_phase_init      (cfg_phase_init),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .epoch_tick          (epoch_tick),
        .busy                (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic t);
        sb.push_back({d, t});
    endtask

    task automatic wr_fcw(input logic [31:0] v);
        cfg_fcw    = v;
        cfg_fcw_wr = 1'b1;
        tick();
        cfg_fcw_wr = 1'b0;
    endtask

    // start pulse, then PRIME (no valid), then first beat visible two cycles on
    task automatic start_run(input logic [31:0] init, input logic [15:0] first);
        cfg_phase_init = init;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("prime_tvalid", {31'd0, tvalid}, 32'd0);
        chk("prime_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("first_tvalid", {31'd0, tvalid}, 32'd1);
        chk("first_tdata", {16'd0, tdata}, {16'd0, first});
    endtask

    task automatic stop_now();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopped_tvalid", {31'd0, tvalid}, 32'd0);
        chk("stopped_busy", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: compare every accepted beat; epoch_tick must be low otherwise.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {16'd0, tdata}, 32'hFFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    chk("beat_tdata", {16'd0, tdata}, {16'd0, e[16:1]});
                    chk("beat_tick", {31'd0, epoch_tick}, {31'd0, e[0]});
                end
            end else begin
                chk("idle_tick", {31'd0, epoch_tick}, 32'd0);
            end
        end
    end

    initial begin
        aresetn        = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        cfg_fcw        = '0;
        cfg_fcw_wr     = 1'b0;
        cfg_phase_init = '0;
        tready         = 1'b1;

        // T1 reset
        repeat (5) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", {16'd0, tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tick", {31'd0, epoch_tick}, 32'd0);
        aresetn = 1'b1;
        repeat (3) tick();
        chk("post_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_tdata", {16'd0, tdata}, 32'd0);

        // T2 ramp of 20 per beat, 10 beats, epoch tick on beat 7
        wr_fcw(32'h0014_0000);
        for (int i = 0; i < 10; i++) push(16'(i * 20), i == 7);
        start_run(32'h0, 16'd0);
        repeat (9) tick();
        stop_now();

        // T3 wrap through zero
        wr_fcw(32'h0010_0000);
        push(16'hFFF0, 1'b0);
        push(16'h0000, 1'b0);
        push(16'h0010, 1'b0);
        push(16'h0020, 1'b0);
        start_run(32'hFFF0_0000, 16'hFFF0);
        repeat (3) tick();
        stop_now();

        // T4 epoch retune: write at beat 3, new step from beat 8 onward
        wr_fcw(32'h0001_0000);
        for (int i = 0; i < 18; i++)
            push((i <= 8) ? 16'(i) : 16'(8 + 2 * (i - 8)), (i == 7) || (i == 15));
        start_run(32'h0, 16'd0);
        repeat (3) tick();
        cfg_fcw = 32'h0002_0000; cfg_fcw_wr = 1'b1;
        tick();
        cfg_fcw_wr = 1'b0;
        repeat (13) tick();
        stop_now();

        // T4b last write wins; a write on the apply cycle waits for the next epoch
        wr_fcw(32'h0001_0000);
        for (int i = 0; i < 18; i++) begin
            if (i <= 8)       push(16'(i), i == 7);
            else if (i <= 16) push(16'(8 + 3 * (i - 8)), i == 15);
            else              push(16'd34, 1'b0);
        end
        start_run(32'h0, 16'd0);
        repeat (2) tick();
        cfg_fcw = 32'h0005_0000; cfg_fcw_wr = 1'b1;
        tick();
        cfg_fcw_wr = 1'b0;
        tick();
        cfg_fcw = 32'h0003_0000; cfg_fcw_wr = 1'b1;
        tick();
        cfg_fcw_wr = 1'b0;
        repeat (2) tick();
        cfg_fcw = 32'h0002_0000; cfg_fcw_wr = 1'b1;
        tick();
        cfg_fcw_wr = 1'b0;
        repeat (9) tick();
        stop_now();

        // T5 backpressure on the epoch's last beat
        wr_fcw(32'h0001_0000);
        for (int i = 0; i < 10; i++) push(16'(i), i == 7);
        start_run(32'h0, 16'd0);
        repeat (7) tick();
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_tvalid", {31'd0, tvalid}, 32'd1);
            chk("bp_tdata", {16'd0, tdata}, 32'd7);
            chk("bp_tick", {31'd0, epoch_tick}, 32'd0);
        end
        tready = 1'b1;
        repeat (2) tick();
        chk("bp_resume_tdata", {16'd0, tdata}, 32'd9);
        stop_now();

        // T6a stop while stalled: STOP holds the beat, start ignored
        push(16'h1234, 1'b0);
        push(16'h1235, 1'b0);
        start_run(32'h1234_0000, 16'h1234);
        tick();
        tready = 1'b0;
        stop   = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd1);
        chk("stop_tvalid", {31'd0, tvalid}, 32'd1);
        chk("stop_tdata", {16'd0, tdata}, 32'h1235);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stop_hold_tdata", {16'd0, tdata}, 32'h1235);
        chk("stop_hold_tvalid", {31'd0, tvalid}, 32'd1);
        tready = 1'b1;
        tick();
        chk("stop_done_tvalid", {31'd0, tvalid}, 32'd0);
        chk("stop_done_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        chk("stop_no_restart", {31'd0, busy}, 32'd0);

        // T6b start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("startstop_tvalid", {31'd0, tvalid}, 32'd0);
            chk("startstop_busy", {31'd0, busy}, 32'd0);
            tick();
        end

        // T6c reset mid-RUN drops tvalid without a clock edge
        tready = 1'b0;
        start_run(32'h5555_0000, 16'h5555);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_tdata", {16'd0, tdata}, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tready  = 1'b1;
        repeat (3) tick();
        chk("arst_stays_idle", {31'd0, tvalid}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
